// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with pause and halt,
// gating raw decoder strobes so each instruction updates state exactly once.
module instr_sequencer #(
    parameter int unsigned FETCH_LAT = 1,
    parameter int unsigned MEM_LAT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        START,
    input  logic        HOLD,
    input  logic [4:0]  OPCODE,
    input  logic        INC_PC,
    input  logic        LOAD_REG,
    input  logic        WRITE,
    input  logic        FINISH,
    output logic        IR_LOAD,
    output logic        DEC_EN,
    output logic        REG_LOAD_EN,
    output logic        PC_INC_EN,
    output logic        PC_CLR,
    output logic        RAM_WRITE_EN,
    output logic        BUSY,
    output logic        DONE,
    output logic [2:0]  STATE,
    output logic [31:0] CYCLE_COUNT,
    output logic [15:0] INSTR_COUNT
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_PAUSE  = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [4:0] OP_LOAD      = 5'b00001;
    localparam logic [4:0] OP_STORE     = 5'b00010;
    localparam logic [3:0] FETCH_RELOAD = 4'(FETCH_LAT - 1);
    localparam logic [3:0] MEM_RELOAD   = 4'(MEM_LAT - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] wait_cnt;
    logic [3:0] next_wait;
    logic       last_wait;
    logic       start_go;

    assign last_wait = (wait_cnt == '0);
    assign start_go  = ((state == S_IDLE) || (state == S_HALT)) && START;

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE, S_HALT: if (START) next_state = S_FETCH;
            S_FETCH:        if (last_wait) next_state = S_DECODE;
            S_DECODE:       next_state = S_EXEC;
            S_EXEC: begin
                if (FINISH)
                    next_state = S_HALT;
                else if ((OPCODE == OP_LOAD) || (OPCODE == OP_STORE))
                    next_state = S_MEM;
                else
                    next_state = S_WB;
            end
            S_MEM:          if (last_wait) next_state = S_WB;
            S_WB:           next_state = HOLD ? S_PAUSE : S_FETCH;
            S_PAUSE:        if (!HOLD) next_state = S_FETCH;
            default:        next_state = S_IDLE;
        endcase
    end

    // Counter counts down to zero and parks there; reload happens only on entry.
    always_comb begin
        next_wait = wait_cnt;
        if (((state == S_FETCH) || (state == S_MEM)) && !last_wait)
            next_wait = wait_cnt - 4'd1;
        if ((next_state == S_FETCH) && (state != S_FETCH))
            next_wait = FETCH_RELOAD;
        else if ((next_state == S_MEM) && (state != S_MEM))
            next_wait = MEM_RELOAD;
    end

    always_comb begin
        IR_LOAD      = 1'b0;
        DEC_EN       = 1'b0;
        REG_LOAD_EN  = 1'b0;
        PC_INC_EN    = 1'b0;
        PC_CLR       = 1'b0;
        RAM_WRITE_EN = 1'b0;
        BUSY         = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC)
                    || (state == S_MEM) || (state == S_WB);
        DONE         = (state == S_HALT);
        STATE        = state;
        // Reset suppresses every strobe in the cycle it is asserted.
        if (!reset) begin
            IR_LOAD      = (state == S_FETCH) && last_wait;
            DEC_EN       = (state == S_DECODE);
            REG_LOAD_EN  = (state == S_WB) && LOAD_REG;
            PC_INC_EN    = (state == S_WB) && INC_PC;
            PC_CLR       = start_go;
            RAM_WRITE_EN = (state == S_MEM) && last_wait && WRITE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            CYCLE_COUNT <= '0;
            INSTR_COUNT <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait;
            if (start_go) begin
                CYCLE_COUNT <= '0;
                INSTR_COUNT <= '0;
            end else begin
                if (BUSY)
                    CYCLE_COUNT <= CYCLE_COUNT + 32'd1;
                if (state == S_WB)
                    INSTR_COUNT <= INSTR_COUNT + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: per-cycle expectations are queued as stimulus is
// driven and compared at the falling edge; tasks add per-scenario pulse checks.
module tb_instr_sequencer;

    localparam int FL = 1;
    localparam int ML = 2;

    localparam logic [5:0] IR   = 6'b100000;
    localparam logic [5:0] DEC  = 6'b010000;
    localparam logic [5:0] CLR  = 6'b000010;
    localparam logic [5:0] RAMW = 6'b000001;

    localparam logic [4:0] OPC_NOP   = 5'b00000;
    localparam logic [4:0] OPC_LOAD  = 5'b00001;
    localparam logic [4:0] OPC_STORE = 5'b00010;
    localparam logic [4:0] OPC_ALU   = 5'b00011;
    localparam logic [4:0] OPC_JMP   = 5'b00100;
    localparam logic [4:0] OPC_FIN   = 5'b11111;

    typedef struct {
        logic        chk;
        logic        reset;
        logic        start;
        logic        hold;
        logic [4:0]  op;
        logic        inc;
        logic        ld;
        logic        wr;
        logic        fin;
        logic [2:0]  st;
        logic [5:0]  strb;
        logic        busy;
        logic        done;
        logic [31:0] cyc;
        logic [15:0] ins;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        START = 1'b0;
    logic        HOLD = 1'b0;
    logic [4:0]  OPCODE = '0;
    logic        INC_PC = 1'b0;
    logic        LOAD_REG = 1'b0;
    logic        WRITE = 1'b0;
    logic        FINISH = 1'b0;
    logic        IR_LOAD, DEC_EN, REG_LOAD_EN, PC_INC_EN, PC_CLR, RAM_WRITE_EN;
    logic        BUSY, DONE;
    logic [2:0]  STATE;
    logic [31:0] CYCLE_COUNT;
    logic [15:0] INSTR_COUNT;

    instr_sequencer #(.FETCH_LAT(FL), .MEM_LAT(ML)) dut (
        .clk(clk), .reset(reset), .START(START), .HOLD(HOLD), .OPCODE(OPCODE),
        .INC_PC(INC_PC), .LOAD_REG(LOAD_REG), .WRITE(WRITE), .FINISH(FINISH),
        .IR_LOAD(IR_LOAD), .DEC_EN(DEC_EN), .REG_LOAD_EN(REG_LOAD_EN),
        .PC_INC_EN(PC_INC_EN), .PC_CLR(PC_CLR), .RAM_WRITE_EN(RAM_WRITE_EN),
        .BUSY(BUSY), .DONE(DONE), .STATE(STATE),
        .CYCLE_COUNT(CYCLE_COUNT), .INSTR_COUNT(INSTR_COUNT)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cnt_ir = 0, cnt_clr = 0, cnt_inc = 0, cnt_ld = 0, cnt_ramw = 0;

    rec_t stim[$];
    rec_t sb[$];

    logic        g_reset = 1'b0, g_start = 1'b0, g_hold = 1'b0;
    logic [4:0]  g_op = '0;
    logic        g_inc = 1'b0, g_ld = 1'b0, g_wr = 1'b0, g_fin = 1'b0;
    logic [31:0] m_cyc = '0;
    logic [15:0] m_ins = '0;

    // Scoreboard: one expected record per driven cycle.
    always @(negedge clk) begin
        rec_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                tests++;
                if (STATE !== e.st
                    || {IR_LOAD, DEC_EN, REG_LOAD_EN, PC_INC_EN, PC_CLR, RAM_WRITE_EN} !== e.strb
                    || BUSY !== e.busy || DONE !== e.done
                    || CYCLE_COUNT !== e.cyc || INSTR_COUNT !== e.ins) begin
                    fails++;
                    $display("FAIL cycle@%0t: state %0d want %0d, strobes %b want %b, busy %b want %b, done %b want %b, cycles %0d want %0d, instrs %0d want %0d",
                             $time, STATE, e.st,
                             {IR_LOAD, DEC_EN, REG_LOAD_EN, PC_INC_EN, PC_CLR, RAM_WRITE_EN}, e.strb,
                             BUSY, e.busy, DONE, e.done, CYCLE_COUNT, e.cyc, INSTR_COUNT, e.ins);
                end
            end
        end
        if (IR_LOAD === 1'b1) cnt_ir++;
        if (PC_CLR === 1'b1) cnt_clr++;
        if (PC_INC_EN === 1'b1) cnt_inc++;
        if (REG_LOAD_EN === 1'b1) cnt_ld++;
        if (RAM_WRITE_EN === 1'b1) cnt_ramw++;
    end

    task automatic put(input logic [2:0] st, input logic [5:0] strb, input logic chk);
        rec_t r;
        r.chk = chk; r.reset = g_reset; r.start = g_start; r.hold = g_hold;
        r.op = g_op; r.inc = g_inc; r.ld = g_ld; r.wr = g_wr; r.fin = g_fin;
        r.st = st; r.strb = strb;
        r.busy = (st >= 3'd1) && (st <= 3'd5);
        r.done = (st == 3'd7);
        r.cyc = m_cyc; r.ins = m_ins;
        stim.push_back(r);
        if (r.busy) m_cyc++;
    endtask

    task automatic put_reset();
        g_reset = 1'b1;
        put(3'd0, '0, 1'b0);
        g_reset = 1'b0;
        m_cyc = '0;
        m_ins = '0;
    endtask

    task automatic start_in(input logic [2:0] st);
        g_start = 1'b1;
        put(st, CLR, 1'b1);
        g_start = 1'b0;
        m_cyc = '0;
        m_ins = '0;
    endtask

    task automatic wait_in(input logic [2:0] st, input int n);
        for (int i = 0; i < n; i++) put(st, '0, 1'b1);
    endtask

    // Decoder strobes are held for the whole instruction so gating is exercised.
    task automatic instr(input logic [4:0] op, input logic inc, input logic ld, input logic wr,
                         input logic fin, input int hold_n, input logic noise);
        g_op = op; g_inc = inc; g_ld = ld; g_wr = wr; g_fin = fin;
        g_start = noise; g_hold = noise;
        for (int i = 0; i < FL; i++) put(3'd1, (i == FL - 1) ? IR : 6'b0, 1'b1);
        put(3'd2, DEC, 1'b1);
        put(3'd3, '0, 1'b1);
        if (!fin) begin
            if (op == OPC_LOAD || op == OPC_STORE)
                for (int i = 0; i < ML; i++) put(3'd4, (i == ML - 1 && wr) ? RAMW : 6'b0, 1'b1);
            g_hold = (hold_n > 0);
            put(3'd5, {2'b00, ld, inc, 2'b00}, 1'b1);
            m_ins++;
            g_start = 1'b0;
            for (int i = 0; i < hold_n; i++) begin
                g_hold = (i < hold_n - 1);
                put(3'd6, '0, 1'b1);
            end
        end
        g_start = 1'b0; g_hold = 1'b0;
    endtask

    task automatic play();
        rec_t r;
        while (stim.size() > 0) begin
            r = stim.pop_front();
            @(posedge clk); #1;
            reset = r.reset; START = r.start; HOLD = r.hold; OPCODE = r.op;
            INC_PC = r.inc; LOAD_REG = r.ld; WRITE = r.wr; FINISH = r.fin;
            sb.push_back(r);
        end
        @(negedge clk); #1;
    endtask

    task automatic clear_counts();
        cnt_ir = 0; cnt_clr = 0; cnt_inc = 0; cnt_ld = 0; cnt_ramw = 0;
    endtask

    task automatic test_reset();
        put_reset();
        put_reset();
        wait_in(3'd0, 10);
        play();
        clear_counts();
        wait_in(3'd0, 2);
        play();
        tests++;
        if (cnt_ir + cnt_clr + cnt_inc + cnt_ld + cnt_ramw !== 0) begin
            fails++;
            $display("FAIL reset_idle_pulses: got %0d strobes, want 0", cnt_ir + cnt_clr + cnt_inc + cnt_ld + cnt_ramw);
        end
    endtask

    task automatic test_nop_program();
        clear_counts();
        start_in(3'd0);
        instr(OPC_NOP, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        instr(OPC_NOP, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        instr(OPC_FIN, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        wait_in(3'd7, 3);
        play();
        tests++;
        if (cnt_clr !== 1 || cnt_ir !== 3 || cnt_inc !== 2) begin
            fails++;
            $display("FAIL nop_pulses: clr %0d ir %0d inc %0d, want 1 3 2", cnt_clr, cnt_ir, cnt_inc);
        end
        tests++;
        if (CYCLE_COUNT !== 32'(2 * (FL + 3) + FL + 2) || INSTR_COUNT !== 16'd2 || DONE !== 1'b1) begin
            fails++;
            $display("FAIL nop_counts: cycles %0d instrs %0d done %b, want %0d 2 1",
                     CYCLE_COUNT, INSTR_COUNT, DONE, 2 * (FL + 3) + FL + 2);
        end
    endtask

    task automatic test_store();
        clear_counts();
        start_in(3'd7);
        instr(OPC_STORE, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        instr(OPC_FIN, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        wait_in(3'd7, 2);
        play();
        tests++;
        if (cnt_ramw !== 1 || cnt_ld !== 0 || cnt_inc !== 1) begin
            fails++;
            $display("FAIL store_pulses: ramw %0d regld %0d inc %0d, want 1 0 1", cnt_ramw, cnt_ld, cnt_inc);
        end
    endtask

    task automatic test_load();
        clear_counts();
        start_in(3'd7);
        instr(OPC_LOAD, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        instr(OPC_FIN, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        wait_in(3'd7, 2);
        play();
        tests++;
        if (cnt_ld !== 1 || cnt_inc !== 1 || cnt_ramw !== 0) begin
            fails++;
            $display("FAIL load_pulses: regld %0d inc %0d ramw %0d, want 1 1 0", cnt_ld, cnt_inc, cnt_ramw);
        end
    endtask

    task automatic test_jmp_hold();
        clear_counts();
        start_in(3'd7);
        instr(OPC_JMP, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0);
        instr(OPC_NOP, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        instr(OPC_FIN, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        wait_in(3'd7, 2);
        play();
        tests++;
        if (cnt_ld !== 1 || cnt_inc !== 1) begin
            fails++;
            $display("FAIL jmp_pulses: regld %0d inc %0d, want 1 1", cnt_ld, cnt_inc);
        end
        tests++;
        if (CYCLE_COUNT !== 32'(2 * (FL + 3) + FL + 2)) begin
            fails++;
            $display("FAIL jmp_pause_cycles: cycles %0d, want %0d", CYCLE_COUNT, 2 * (FL + 3) + FL + 2);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        start_in(3'd7);
        instr(OPC_NOP,   1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        instr(OPC_STORE, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        instr(OPC_LOAD,  1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        instr(OPC_JMP,   1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        instr(OPC_STORE, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        instr(OPC_ALU,   1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        instr(OPC_FIN,   1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        wait_in(3'd7, 2);
        play();
        tests++;
        if (cnt_ramw !== 1 || cnt_ld !== 3 || cnt_inc !== 5 || cnt_ir !== 7 || cnt_clr !== 1) begin
            fails++;
            $display("FAIL b2b_pulses: ramw %0d regld %0d inc %0d ir %0d clr %0d, want 1 3 5 7 1",
                     cnt_ramw, cnt_ld, cnt_inc, cnt_ir, cnt_clr);
        end
        tests++;
        if (INSTR_COUNT !== 16'd6 || CYCLE_COUNT !== 32'(3 * (FL + 3) + 3 * (FL + ML + 3) + FL + 2)) begin
            fails++;
            $display("FAIL b2b_counts: instrs %0d cycles %0d, want 6 %0d",
                     INSTR_COUNT, CYCLE_COUNT, 3 * (FL + 3) + 3 * (FL + ML + 3) + FL + 2);
        end
    endtask

    task automatic test_reset_mid_mem();
        clear_counts();
        start_in(3'd7);
        g_op = OPC_STORE; g_inc = 1'b1; g_ld = 1'b1; g_wr = 1'b1; g_fin = 1'b0;
        for (int i = 0; i < FL; i++) put(3'd1, (i == FL - 1) ? IR : 6'b0, 1'b1);
        put(3'd2, DEC, 1'b1);
        put(3'd3, '0, 1'b1);
        put_reset();
        wait_in(3'd0, 3);
        g_op = '0; g_inc = 1'b0; g_ld = 1'b0; g_wr = 1'b0;
        wait_in(3'd0, 2);
        play();
        tests++;
        if (cnt_ramw !== 0 || cnt_ld !== 0 || cnt_inc !== 0 || STATE !== 3'd0) begin
            fails++;
            $display("FAIL reset_abort: ramw %0d regld %0d inc %0d state %0d, want 0 0 0 0",
                     cnt_ramw, cnt_ld, cnt_inc, STATE);
        end
        clear_counts();
        start_in(3'd0);
        instr(OPC_FIN, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        wait_in(3'd7, 2);
        start_in(3'd7);
        instr(OPC_NOP, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        instr(OPC_FIN, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        wait_in(3'd7, 1);
        play();
        tests++;
        if (cnt_clr !== 2 || INSTR_COUNT !== 16'd1 || CYCLE_COUNT !== 32'((FL + 3) + FL + 2)) begin
            fails++;
            $display("FAIL restart_counts: clr %0d instrs %0d cycles %0d, want 2 1 %0d",
                     cnt_clr, INSTR_COUNT, CYCLE_COUNT, (FL + 3) + FL + 2);
        end
    endtask

    initial begin
        test_reset();
        test_nop_program();
        test_store();
        test_load();
        test_jmp_hold();
        test_back_to_back();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
